// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 32-bit RISC-V words behind a 2-entry output FIFO.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instruction_encoder #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [Width-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [7:0]       err_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        imm_bad;
  logic        push;
  logic        pop;
  logic        ready_en;
  logic [1:0]  count;
  logic        wptr;
  logic        rptr;
  logic [31:0] mem_instr [2];
  logic        mem_err   [2];

`ifdef IMM_RANGE_CHECK_EN
  logic imm12_ok;
  logic imm20_ok;
  logic is_12bit_op;

  // An immediate fits when every bit above the sign bit equals the sign bit.
  assign imm12_ok = (in_imm[Width-1:11] == '0) || (in_imm[Width-1:11] == '1);
  assign imm20_ok = (in_imm[Width-1:19] == '0) || (in_imm[Width-1:19] == '1);
  assign is_12bit_op = (in_opcode == OP_LOAD) || (in_opcode == OP_IMM) ||
                       (in_opcode == OP_JALR) || (in_opcode == OP_STORE) ||
                       (in_opcode == OP_BRANCH);
  assign imm_bad = ((in_opcode == OP_JAL) && !imm20_ok) || (is_12bit_op && !imm12_ok);
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^in_imm[Width-1:20];
  assign imm_bad = 1'b0;
`endif

  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b1;
    case (in_opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = imm_bad;
      end
      OP_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = imm_bad;
      end
      OP_BRANCH: begin
        // in_imm is in halfword units, so bit n here is offset bit n+1.
        enc_instr = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                     in_imm[3:0], in_imm[10], in_opcode};
        enc_err   = imm_bad;
      end
      OP_JAL: begin
        enc_instr = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11], in_rd, in_opcode};
        enc_err   = imm_bad;
      end
      OP_REG: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

  // in_ready depends only on registered state, so out_ready never reaches it combinationally.
  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = mem_instr[rptr];
  assign out_err   = mem_err[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en     <= 1'b0;
      count        <= 2'd0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      mem_instr[0] <= 32'h0;
      mem_instr[1] <= 32'h0;
      mem_err[0]   <= 1'b0;
      mem_err[1]   <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        mem_instr[wptr] <= enc_instr;
        mem_err[wptr]   <= enc_err;
        wptr            <= ~wptr;
        if (enc_err && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
